// File: rtl/panda_risc_v_long_inst_scoreboard_if.sv
// Dispatcher <-> long-instruction scoreboard signal bundle.
// master: dispatcher / LSU / mul-div side; slave: the scoreboard itself.
interface panda_risc_v_long_inst_scoreboard_if #(
  parameter int unsigned ENTRY_N = 4
);
  localparam int unsigned TAG_W = $clog2(ENTRY_N);

  // allocation
  logic             alloc_valid;
  logic             alloc_ready;
  logic [4:0]       alloc_rd_id;
  logic             alloc_rd_vld;
  logic [TAG_W-1:0] alloc_tag;
  // hazard checks
  logic [4:0]       chk_rd_id;
  logic             chk_rd_waw;
  logic [4:0]       chk_rs1_id;
  logic             chk_rs1_raw;
  logic [4:0]       chk_rs2_id;
  logic             chk_rs2_raw;
  // retire ports (0: LSU, 1: mul/div)
  logic             ret0_valid;
  logic [TAG_W-1:0] ret0_tag;
  logic             ret1_valid;
  logic [TAG_W-1:0] ret1_tag;
  // status
  logic [TAG_W:0]   outstanding_n;
  logic             sb_empty;
  logic             sb_err;

  modport master (
    output alloc_valid, alloc_rd_id, alloc_rd_vld,
    output chk_rd_id, chk_rs1_id, chk_rs2_id,
    output ret0_valid, ret0_tag, ret1_valid, ret1_tag,
    input  alloc_ready, alloc_tag, chk_rd_waw, chk_rs1_raw, chk_rs2_raw,
    input  outstanding_n, sb_empty, sb_err
  );

  modport slave (
    input  alloc_valid, alloc_rd_id, alloc_rd_vld,
    input  chk_rd_id, chk_rs1_id, chk_rs2_id,
    input  ret0_valid, ret0_tag, ret1_valid, ret1_tag,
    output alloc_ready, alloc_tag, chk_rd_waw, chk_rs1_raw, chk_rs2_raw,
    output outstanding_n, sb_empty, sb_err
  );
endinterface

// File: rtl/panda_risc_v_long_inst_scoreboard.sv
// Long-instruction scoreboard: tracks dispatched L/S, mul and div/rem
// instructions until their unit retires them by tag, and reports RD WAW and
// RS1/RS2 RAW hazards to the dispatcher from registered entry state only.
module panda_risc_v_long_inst_scoreboard #(
  parameter int unsigned ENTRY_N   = 4,
  parameter int unsigned SIM_DELAY = 1
) (
  input logic clk,
  input logic rst_n,
  panda_risc_v_long_inst_scoreboard_if.slave sb
);
  localparam int unsigned TAG_W = $clog2(ENTRY_N);

  if (ENTRY_N != 2 && ENTRY_N != 4 && ENTRY_N != 8) begin : g_bad_entry_n
    $error("ENTRY_N=%0d unsupported (SIM_DELAY=%0d)", ENTRY_N, SIM_DELAY);
  end

  logic [ENTRY_N-1:0] vld;
  logic [ENTRY_N-1:0] rd_vld;
  logic [4:0]         rd_id [ENTRY_N];
  logic [TAG_W:0]     cnt;
  logic               empty_q;
  logic               err_q;

  logic               alloc_ready;
  logic [TAG_W-1:0]   alloc_tag;
  logic               alloc_fire;
  logic               r0_ok, r1_ok, same_tag, err_set;
  logic [ENTRY_N-1:0] clr_mask, set_mask;
  logic [TAG_W:0]     ret_n;
  logic [TAG_W:0]     cnt_nxt;
  logic               waw, raw1, raw2;

  assign alloc_ready = ~&vld;
  assign alloc_fire  = sb.alloc_valid & alloc_ready;

  // lowest free entry is the one granted
  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_tag = '0;
    for (int unsigned i = 0; i < ENTRY_N; i++) begin
      if (!vld[i] && !found) begin
        alloc_tag = TAG_W'(i);
        found     = 1'b1;
      end
    end
  end

  // retire decode; a double retire of one valid tag counts once and is not an error
  always_comb begin
    r0_ok    = sb.ret0_valid & vld[sb.ret0_tag];
    r1_ok    = sb.ret1_valid & vld[sb.ret1_tag];
    same_tag = sb.ret0_valid & sb.ret1_valid & (sb.ret0_tag == sb.ret1_tag);
    err_set  = (sb.ret0_valid & ~vld[sb.ret0_tag]) | (sb.ret1_valid & ~vld[sb.ret1_tag]);
    ret_n    = (TAG_W+1)'(r0_ok) + (TAG_W+1)'(r1_ok & ~same_tag);
    clr_mask = '0;
    set_mask = '0;
    for (int unsigned i = 0; i < ENTRY_N; i++) begin
      clr_mask[i] = (r0_ok && sb.ret0_tag == TAG_W'(i)) || (r1_ok && sb.ret1_tag == TAG_W'(i));
      set_mask[i] = alloc_fire && (alloc_tag == TAG_W'(i));
    end
    cnt_nxt = cnt + (TAG_W+1)'(alloc_fire) - ret_n;
  end

  // hazard match against registered entries only
  always_comb begin
    waw  = 1'b0;
    raw1 = 1'b0;
    raw2 = 1'b0;
    for (int unsigned i = 0; i < ENTRY_N; i++) begin
      waw  = waw  | (vld[i] & rd_vld[i] & (rd_id[i] == sb.chk_rd_id));
      raw1 = raw1 | (vld[i] & rd_vld[i] & (rd_id[i] == sb.chk_rs1_id));
      raw2 = raw2 | (vld[i] & rd_vld[i] & (rd_id[i] == sb.chk_rs2_id));
    end
    waw  = waw  & (sb.chk_rd_id  != 5'd0);
    raw1 = raw1 & (sb.chk_rs1_id != 5'd0);
    raw2 = raw2 & (sb.chk_rs2_id != 5'd0);
  end

  // entry state: allocate into free slots, clear retired slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      rd_vld <= '0;
      for (int unsigned i = 0; i < ENTRY_N; i++) rd_id[i] <= '0;
    end else begin
      vld    <= (vld & ~clr_mask) | set_mask;
      for (int unsigned i = 0; i < ENTRY_N; i++) begin
        if (set_mask[i]) begin
          rd_id[i]  <= sb.alloc_rd_id;
          rd_vld[i] <= sb.alloc_rd_vld & (sb.alloc_rd_id != 5'd0);
        end else if (clr_mask[i]) begin
          rd_vld[i] <= 1'b0;
        end
      end
    end
  end

  // registered occupancy and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      err_q   <= err_q | err_set;
    end
  end

  assign sb.alloc_ready   = alloc_ready;
  assign sb.alloc_tag     = alloc_tag;
  assign sb.chk_rd_waw    = waw;
  assign sb.chk_rs1_raw   = raw1;
  assign sb.chk_rs2_raw   = raw2;
  assign sb.outstanding_n = cnt;
  assign sb.sb_empty      = empty_q;
  assign sb.sb_err        = err_q;
endmodule

// File: tb/tb_panda_risc_v_long_inst_scoreboard.sv
// Directed bench for the long-instruction scoreboard: a vector table walked
// cycle by cycle, then hand sequences for dual retire, visibility latency
// and asynchronous reset.
module tb_panda_risc_v_long_inst_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  panda_risc_v_long_inst_scoreboard_if #(.ENTRY_N(4)) sb_if ();

  panda_risc_v_long_inst_scoreboard #(.ENTRY_N(4), .SIM_DELAY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  typedef struct {
    logic       av;  logic [4:0] ard;  logic arv;
    logic [4:0] crd; logic [4:0] crs1; logic [4:0] crs2;
    logic       r0v; logic [1:0] r0t;  logic r1v; logic [1:0] r1t;
    logic       e_rdy; logic [1:0] e_tag;
    logic       e_waw; logic e_raw1; logic e_raw2;
    logic [2:0] e_out; logic e_empty; logic e_err;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(
    input logic av, input int ard, input logic arv,
    input int crd, input int crs1, input int crs2,
    input logic r0v, input int r0t, input logic r1v, input int r1t,
    input logic rdy, input int tag, input logic waw, input logic raw1, input logic raw2,
    input int outn, input logic empty, input logic err);
    vec_t v;
    v.av = av; v.ard = 5'(ard); v.arv = arv;
    v.crd = 5'(crd); v.crs1 = 5'(crs1); v.crs2 = 5'(crs2);
    v.r0v = r0v; v.r0t = 2'(r0t); v.r1v = r1v; v.r1t = 2'(r1t);
    v.e_rdy = rdy; v.e_tag = 2'(tag); v.e_waw = waw; v.e_raw1 = raw1; v.e_raw2 = raw2;
    v.e_out = 3'(outn); v.e_empty = empty; v.e_err = err;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input int ard, input logic arv,
                       input int crd, input int crs1, input int crs2,
                       input logic r0v, input int r0t, input logic r1v, input int r1t);
    sb_if.alloc_valid  = av;
    sb_if.alloc_rd_id  = 5'(ard);
    sb_if.alloc_rd_vld = arv;
    sb_if.chk_rd_id    = 5'(crd);
    sb_if.chk_rs1_id   = 5'(crs1);
    sb_if.chk_rs2_id   = 5'(crs2);
    sb_if.ret0_valid   = r0v;
    sb_if.ret0_tag     = 2'(r0t);
    sb_if.ret1_valid   = r1v;
    sb_if.ret1_tag     = 2'(r1t);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          av ard arv crd rs1 rs2 r0v r0t r1v r1t rdy tag waw r1 r2 out emp err
    vt[0]  = mk(1, 5, 1,  5,  5,  0,  0, 0,  0, 0,  1,  0,  0, 0, 0, 0, 1, 0);
    vt[1]  = mk(0, 0, 0,  5,  5,  5,  0, 0,  0, 0,  1,  1,  1, 1, 1, 1, 0, 0);
    vt[2]  = mk(1, 1, 1,  1,  0,  0,  0, 0,  0, 0,  1,  1,  0, 0, 0, 1, 0, 0);
    vt[3]  = mk(1, 2, 1,  1,  0,  0,  0, 0,  0, 0,  1,  2,  1, 0, 0, 2, 0, 0);
    vt[4]  = mk(1, 3, 1,  0,  0,  0,  0, 0,  0, 0,  1,  3,  0, 0, 0, 3, 0, 0);
    vt[5]  = mk(1, 4, 1,  4,  3,  2,  0, 0,  0, 0,  0,  0,  0, 1, 1, 4, 0, 0);
    vt[6]  = mk(1, 4, 1,  0,  0,  2,  0, 0,  1, 2,  0,  0,  0, 0, 1, 4, 0, 0);
    vt[7]  = mk(1, 4, 1,  0,  0,  2,  0, 0,  0, 0,  1,  2,  0, 0, 0, 3, 0, 0);
    vt[8]  = mk(0, 0, 0,  4,  0,  0,  1, 0,  1, 1,  0,  0,  1, 0, 0, 4, 0, 0);
    vt[9]  = mk(0, 0, 0,  5,  3,  0,  1, 2,  1, 3,  1,  0,  0, 1, 0, 2, 0, 0);
    vt[10] = mk(0, 0, 0,  0,  3,  0,  1, 3,  0, 0,  1,  0,  0, 0, 0, 0, 1, 0);
    vt[11] = mk(1, 0, 1,  0,  0,  0,  0, 0,  0, 0,  1,  0,  0, 0, 0, 0, 1, 1);
    vt[12] = mk(1, 9, 0,  0,  0,  0,  0, 0,  0, 0,  1,  1,  0, 0, 0, 1, 0, 1);
    vt[13] = mk(0, 0, 0,  9,  9,  0,  1, 0,  1, 0,  1,  2,  0, 0, 0, 2, 0, 1);
    vt[14] = mk(0, 0, 0,  0,  0,  0,  1, 1,  0, 0,  1,  0,  0, 0, 0, 1, 0, 1);
    vt[15] = mk(0, 0, 0,  0,  0,  0,  0, 0,  0, 0,  1,  0,  0, 0, 0, 0, 1, 1);

    idle();
    #22;
    check("reset_outstanding", int'(sb_if.outstanding_n), 0);
    check("reset_empty", int'(sb_if.sb_empty), 1);
    check("reset_err", int'(sb_if.sb_err), 0);
    check("reset_ready", int'(sb_if.alloc_ready), 1);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].av, int'(vt[i].ard), vt[i].arv, int'(vt[i].crd), int'(vt[i].crs1),
            int'(vt[i].crs2), vt[i].r0v, int'(vt[i].r0t), vt[i].r1v, int'(vt[i].r1t));
      #1;
      check($sformatf("v%0d_ready", i), int'(sb_if.alloc_ready), int'(vt[i].e_rdy));
      if (vt[i].e_rdy)
        check($sformatf("v%0d_tag", i), int'(sb_if.alloc_tag), int'(vt[i].e_tag));
      check($sformatf("v%0d_waw", i), int'(sb_if.chk_rd_waw), int'(vt[i].e_waw));
      check($sformatf("v%0d_rs1", i), int'(sb_if.chk_rs1_raw), int'(vt[i].e_raw1));
      check($sformatf("v%0d_rs2", i), int'(sb_if.chk_rs2_raw), int'(vt[i].e_raw2));
      check($sformatf("v%0d_outstanding", i), int'(sb_if.outstanding_n), int'(vt[i].e_out));
      check($sformatf("v%0d_empty", i), int'(sb_if.sb_empty), int'(vt[i].e_empty));
      check($sformatf("v%0d_err", i), int'(sb_if.sb_err), int'(vt[i].e_err));
      next_cycle();
    end

    // reset clears the sticky error
    idle();
    rst_n = 1'b0;
    #1;
    check("rst1_err", int'(sb_if.sb_err), 0);
    check("rst1_empty", int'(sb_if.sb_empty), 1);
    #2;
    rst_n = 1'b1;
    next_cycle();

    // two entries retired on both ports in one cycle
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("dual_tag0", int'(sb_if.alloc_tag), 0);
    next_cycle();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("dual_tag1", int'(sb_if.alloc_tag), 1);
    next_cycle();
    drive(0, 0, 0, 7, 9, 0, 1, 0, 1, 1);
    #1;
    check("dual_waw_before", int'(sb_if.chk_rd_waw), 1);
    check("dual_rs1_before", int'(sb_if.chk_rs1_raw), 1);
    check("dual_out_before", int'(sb_if.outstanding_n), 2);
    next_cycle();
    drive(0, 0, 0, 7, 9, 0, 0, 0, 0, 0);
    #1;
    check("dual_waw_after", int'(sb_if.chk_rd_waw), 0);
    check("dual_rs1_after", int'(sb_if.chk_rs1_raw), 0);
    check("dual_empty_after", int'(sb_if.sb_empty), 1);
    check("dual_out_after", int'(sb_if.outstanding_n), 0);

    // allocation visible one cycle later; bad retire in same cycle sets err
    drive(1, 6, 1, 0, 0, 6, 1, 3, 0, 0);
    #1;
    check("vis_rs2_n", int'(sb_if.chk_rs2_raw), 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 6, 0, 0, 0, 0);
    #1;
    check("vis_rs2_n1", int'(sb_if.chk_rs2_raw), 1);
    check("vis_out", int'(sb_if.outstanding_n), 1);
    check("vis_err", int'(sb_if.sb_err), 1);
    check("vis_tag", int'(sb_if.alloc_tag), 1);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("arst_rs2", int'(sb_if.chk_rs2_raw), 0);
    check("arst_ready", int'(sb_if.alloc_ready), 1);
    check("arst_tag", int'(sb_if.alloc_tag), 0);
    check("arst_out", int'(sb_if.outstanding_n), 0);
    check("arst_empty", int'(sb_if.sb_empty), 1);
    check("arst_err", int'(sb_if.sb_err), 0);
    #2;
    rst_n = 1'b1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
